uart_fifo_core: RTL and testbench

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_fifo_core.sv | 274 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared constants and helpers for the UART FIFO core:
//   - parity-mode codes (none / odd / even)
//   - FSM state encodings used by both the transmitter and the receiver
//   - uart_divisor(): clock cycles per 16x oversampling tick
//   - parity_bit(): parity bit for a character, computed over data bits only
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Rounded clk_freq / (16 * baud), never below one cycle per tick.
  function automatic int uart_divisor(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + 8 * baud) / (16 * baud);
    if (d < 1) d = 1;
    return d;
  endfunction

  // Characters narrower than 8 bits are zero-extended by the caller; the
  // extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    case (mode)
      PARITY_ODD:  p = ~(^data);
      PARITY_EVEN: p = ^data;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo
//   First-word-fall-through synchronous FIFO.
//   Ports:
//     clk, rst      system clock, asynchronous active-low reset
//     wr, wdata     push strobe and data (ignored when full, unless popping)
//     rd            pop strobe (ignored when empty)
//     rdata         head entry, valid whenever empty=0, zero when empty
//     full, empty   occupancy flags
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_rd = rd && !empty;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign do_wr = wr && (!full || do_rd);
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core
//   UART transmitter and receiver, each buffered by a FIFO.
//   Ports:
//     clk, rst                  system clock, asynchronous active-low reset
//     tx_data, tx_wr, tx_full   TX FIFO push side
//     rx_data, rx_rd, rx_empty  RX FIFO pop side (first-word-fall-through)
//     uart_rxd, uart_txd        serial line in / out
//     parity_err, frame_err,
//     overrun                   sticky receive errors
//     err_clr                   clears all three error flags
module uart_fifo_core import uart_pkg::*; #(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 1152000,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_rd,
  output logic                 rx_empty,
  input  logic                 uart_rxd,
  output logic                 uart_txd,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int               DIVISOR   = uart_divisor(clk_freq, uart_baud_rate);
  localparam int               DIV_W     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIVISOR - 1);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  logic [2:0]           tx_state;
  logic [DIV_W-1:0]     tx_div_cnt;
  logic [3:0]           tx_tick_cnt;
  logic [2:0]           tx_bit_cnt;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_tick;
  logic                 tx_bit_done;
  logic                 tx_pop;
  logic                 tx_fifo_empty;
  logic [DATA_BITS-1:0] tx_fifo_rdata;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (tx_pop),
    .rdata (tx_fifo_rdata),
    .full  (tx_full),
    .empty (tx_fifo_empty)
  );

  assign tx_tick     = (tx_state != ST_IDLE) && (tx_div_cnt == DIV_LAST);
  assign tx_bit_done = tx_tick && (tx_tick_cnt == 4'd15);
  // Load the next character either from idle or straight out of the last
  // stop bit, which keeps consecutive frames gap-free.
  assign tx_pop = !tx_fifo_empty &&
                  ((tx_state == ST_IDLE) ||
                   ((tx_state == ST_STOP) && tx_bit_done && (tx_bit_cnt == LAST_STOP)));

  // Tick counters are held at zero in idle so every frame starts on a fresh
  // bit phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state    <= ST_IDLE;
      tx_div_cnt  <= '0;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shreg    <= '0;
      tx_par      <= 1'b0;
    end else begin
      if (tx_state == ST_IDLE) begin
        tx_div_cnt  <= '0;
        tx_tick_cnt <= '0;
      end else if (tx_tick) begin
        tx_div_cnt  <= '0;
        tx_tick_cnt <= tx_tick_cnt + 4'd1;
      end else begin
        tx_div_cnt  <= tx_div_cnt + DIV_W'(1);
      end

      if (tx_pop) begin
        tx_shreg   <= tx_fifo_rdata;
        tx_par     <= parity_bit(8'(tx_fifo_rdata), PARITY);
        tx_bit_cnt <= '0;
        tx_state   <= ST_START;
      end else if (tx_bit_done) begin
        case (tx_state)
          ST_START: begin
            tx_state   <= ST_DATA;
            tx_bit_cnt <= '0;
          end
          ST_DATA: begin
            tx_shreg <= tx_shreg >> 1;
            if (tx_bit_cnt == LAST_DATA) begin
              tx_bit_cnt <= '0;
              tx_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              tx_bit_cnt <= tx_bit_cnt + 3'd1;
            end
          end
          ST_PARITY: begin
            tx_state   <= ST_STOP;
            tx_bit_cnt <= '0;
          end
          ST_STOP: begin
            if (tx_bit_cnt == LAST_STOP) tx_state   <= ST_IDLE;
            else                         tx_bit_cnt <= tx_bit_cnt + 3'd1;
          end
          default: tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Registered line driver: the line trails the state by one cycle, so the
  // start bit appears two cycles after a write into an idle transmitter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        ST_START:  uart_txd <= 1'b0;
        ST_DATA:   uart_txd <= tx_shreg[0];
        ST_PARITY: uart_txd <= tx_par;
        default:   uart_txd <= 1'b1;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic                 rxd_meta;
  logic                 rxd_sync;
  logic                 rxd_prev;
  logic [2:0]           rx_state;
  logic [DIV_W-1:0]     rx_div_cnt;
  logic [3:0]           rx_tick_cnt;
  logic [2:0]           rx_bit_cnt;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par_pend;
  logic                 rx_wait_high;
  logic                 rx_sample;
  logic                 rx_stop_ok;
  logic                 rx_stop_bad;
  logic                 rx_fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Every decision is taken on the 8th tick of a bit period, i.e. mid-bit.
  assign rx_sample   = (rx_state != ST_IDLE) && (rx_div_cnt == DIV_LAST) &&
                       (rx_tick_cnt == 4'd7);
  assign rx_stop_ok  = (rx_state == ST_STOP) && !rx_wait_high && rx_sample && rxd_sync;
  assign rx_stop_bad = (rx_state == ST_STOP) && !rx_wait_high && rx_sample && !rxd_sync;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (rx_stop_ok),
    .wdata (rx_shreg),
    .rd    (rx_rd),
    .rdata (rx_data),
    .full  (rx_fifo_full),
    .empty (rx_empty)
  );

  // After a bad stop bit the FSM parks in STOP (rx_wait_high) until the line
  // idles, so a held-low line cannot fake a new start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state     <= ST_IDLE;
      rx_div_cnt   <= '0;
      rx_tick_cnt  <= '0;
      rx_bit_cnt   <= '0;
      rx_shreg     <= '0;
      rx_par_pend  <= 1'b0;
      rx_wait_high <= 1'b0;
    end else begin
      if (rx_state == ST_IDLE) begin
        rx_div_cnt  <= '0;
        rx_tick_cnt <= '0;
      end else if (rx_div_cnt == DIV_LAST) begin
        rx_div_cnt  <= '0;
        rx_tick_cnt <= rx_tick_cnt + 4'd1;
      end else begin
        rx_div_cnt  <= rx_div_cnt + DIV_W'(1);
      end

      case (rx_state)
        ST_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            rx_state     <= ST_START;
            rx_par_pend  <= 1'b0;
            rx_wait_high <= 1'b0;
          end
        end
        ST_START: begin
          if (rx_sample) begin
            if (rxd_sync) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_state   <= ST_DATA;
              rx_bit_cnt <= '0;
            end
          end
        end
        ST_DATA: begin
          if (rx_sample) begin
            rx_shreg <= {rxd_sync, rx_shreg[DATA_BITS-1:1]};
            if (rx_bit_cnt == LAST_DATA) begin
              rx_bit_cnt <= '0;
              rx_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              rx_bit_cnt <= rx_bit_cnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (rx_sample) begin
            rx_par_pend <= (rxd_sync != parity_bit(8'(rx_shreg), PARITY));
            rx_state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (rx_wait_high) begin
            if (rxd_sync) begin
              rx_wait_high <= 1'b0;
              rx_state     <= ST_IDLE;
            end
          end else if (rx_sample) begin
            if (rxd_sync) rx_state     <= ST_IDLE;
            else          rx_wait_high <= 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= (rx_stop_ok && rx_par_pend) || (parity_err && !err_clr);
      frame_err  <= rx_stop_bad || (frame_err && !err_clr);
      overrun    <= (rx_stop_ok && rx_fifo_full && !rx_rd) || (overrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core
//   Drives two cores (8N1 default, and 7E1 with a depth-4 FIFO). Frames are
//   built and decoded bit by bit from the line format; received characters
//   are compared against queues of what was sent.
`timescale 1ns/1ps
module tb_uart_fifo_core;

  localparam int CLK_HZ  = 100000000;
  localparam int BAUD    = 1152000;
  localparam int DIV_RAW = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int BIT_CYC = 16 * ((DIV_RAW < 1) ? 1 : DIV_RAW);
  localparam int TIMEOUT = 4 * 12 * BIT_CYC;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_data0, rx_data0;
  logic       tx_wr0, tx_full0, rx_rd0, rx_empty0, txd0, rxd0, drv0, loop0;
  logic       perr0, ferr0, ovr0, clr0;
  logic [6:0] tx_data1, rx_data1;
  logic       tx_wr1, tx_full1, rx_rd1, rx_empty1, txd1, drv1;
  logic       perr1, ferr1, ovr1, clr1;

  assign rxd0 = loop0 ? txd0 : drv0;

  uart_fifo_core dut0 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_full(tx_full0),
    .rx_data(rx_data0), .rx_rd(rx_rd0), .rx_empty(rx_empty0),
    .uart_rxd(rxd0), .uart_txd(txd0),
    .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .err_clr(clr0)
  );

  uart_fifo_core #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst),
    .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_full(tx_full1),
    .rx_data(rx_data1), .rx_rd(rx_rd1), .rx_empty(rx_empty1),
    .uart_rxd(drv1), .uart_txd(txd1),
    .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .err_clr(clr1)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame as it appears on the line: bit 0 = start, then data LSB first,
  // optional parity, then stop bits (all unused positions read as idle 1).
  function automatic logic [15:0] line_frame(input logic [7:0] d, input int nd, input int pmode);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < nd; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
    if (pmode == 2) f[1+nd] = (ones % 2 == 1);
    if (pmode == 1) f[1+nd] = (ones % 2 == 0);
    return f;
  endfunction

  function automatic logic get_txd(input int which);
    return (which == 0) ? txd0 : txd1;
  endfunction

  task automatic set_line(input int which, input logic v);
    if (which == 0) drv0 = v;
    else            drv1 = v;
  endtask

  task automatic send_bits(input int which, input logic [15:0] f, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      set_line(which, f[k]);
      tick(BIT_CYC);
    end
    set_line(which, 1'b1);
  endtask

  task automatic write_tx(input int which, input logic [7:0] d);
    if (which == 0) begin tx_data0 = d;      tx_wr0 = 1'b1; end
    else            begin tx_data1 = d[6:0]; tx_wr1 = 1'b1; end
    tick(1);
    tx_wr0 = 1'b0;
    tx_wr1 = 1'b0;
  endtask

  task automatic wait_rx(input int which, input string tag);
    logic empty;
    empty = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      empty = (which == 0) ? rx_empty0 : rx_empty1;
      if (!empty) break;
      tick(1);
    end
    check_output(tag, !empty, 1);
  endtask

  task automatic pop_rx(input int which, output logic [7:0] d);
    if (which == 0) begin d = rx_data0;         rx_rd0 = 1'b1; end
    else            begin d = {1'b0, rx_data1}; rx_rd1 = 1'b1; end
    tick(1);
    rx_rd0 = 1'b0;
    rx_rd1 = 1'b0;
  endtask

  task automatic pulse_clr(input int which);
    if (which == 0) clr0 = 1'b1;
    else            clr1 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    clr1 = 1'b0;
  endtask

  // Waits for a start bit and samples every bit mid-period.
  task automatic capture_frame(input int which, input int nbits, input string tag,
                               output logic [15:0] bits, output int start_cyc);
    logic found;
    found = 1'b0;
    bits = '1;
    start_cyc = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (get_txd(which) == 1'b0) begin found = 1'b1; break; end
      tick(1);
    end
    check_output(tag, found, 1);
    if (found) begin
      start_cyc = cyc;
      tick(BIT_CYC / 2);
      bits[0] = get_txd(which);
      for (int k = 1; k < nbits; k++) begin
        tick(BIT_CYC);
        bits[k] = get_txd(which);
      end
    end
  endtask

  task automatic apply_stimulus();
    logic [7:0]  d;
    logic [7:0]  exp_q[$];
    logic [15:0] f;
    int          starts[8];
    int          lows;

    // Reset state
    rst = 1'b0;
    tick(3);
    check_output("rst_txd", txd0, 1);
    check_output("rst_tx_full", tx_full0, 0);
    check_output("rst_rx_empty", rx_empty0, 1);
    check_output("rst_rx_data", rx_data0, 0);
    check_output("rst_errs", {perr0, ferr0, ovr0}, 0);
    check_output("rst_txd1", txd1, 1);
    rst = 1'b1;
    tick(2);

    // Loopback of 0xA5 with exact start-bit latency
    loop0 = 1'b1;
    write_tx(0, 8'hA5);
    check_output("txd_lat0", txd0, 1);
    tick(1);
    check_output("txd_lat1", txd0, 1);
    tick(1);
    check_output("txd_lat2", txd0, 0);
    f = '1;
    tick(BIT_CYC / 2 - 1);
    f[0] = txd0;
    for (int k = 1; k < 10; k++) begin
      tick(BIT_CYC);
      f[k] = txd0;
    end
    check_output("a5_frame", f, line_frame(8'hA5, 8, 0));
    wait_rx(0, "a5_rx_wait");
    pop_rx(0, d);
    check_output("a5_rx_data", d, 8'hA5);
    check_output("a5_rx_empty", rx_empty0, 1);

    // Random back-to-back loopback
    for (int i = 0; i < 8; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    fork
      begin
        for (int i = 0; i < 8; i++) write_tx(0, exp_q[i]);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          capture_frame(0, 10, "b2b_start", f, starts[i]);
          check_output("b2b_frame", f, line_frame(exp_q[i], 8, 0));
          if (i > 0) check_output("b2b_gap", starts[i] - starts[i-1], 10 * BIT_CYC);
        end
      end
    join
    for (int i = 0; i < 8; i++) begin
      wait_rx(0, "b2b_rx_wait");
      pop_rx(0, d);
      check_output("b2b_rx_data", d, exp_q[i]);
    end
    loop0 = 1'b0;
    drv0 = 1'b1;
    tick(BIT_CYC);

    // Framing error: 0x3C with stop bit 0, then recovery
    f = line_frame(8'h3C, 8, 0);
    f[9] = 1'b0;
    send_bits(0, f, 10);
    tick(BIT_CYC);
    check_output("ferr_set", ferr0, 1);
    check_output("ferr_rx_empty", rx_empty0, 1);
    d = 8'($urandom_range(0, 255));
    send_bits(0, line_frame(d, 8, 0), 10);
    wait_rx(0, "ferr_recover_wait");
    check_output("ferr_recover_data", rx_data0, d);
    pop_rx(0, d);
    pulse_clr(0);
    check_output("ferr_clr", ferr0, 0);

    // 3-cycle glitch on the line
    drv0 = 1'b0;
    tick(3);
    drv0 = 1'b1;
    tick(3 * BIT_CYC);
    check_output("glitch_empty", rx_empty0, 1);
    check_output("glitch_errs", {perr0, ferr0, ovr0}, 0);

    // Overrun: 17 characters into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_bits(0, line_frame(8'(i), 8, 0), 10);
    tick(BIT_CYC);
    check_output("ovr_set", ovr0, 1);
    for (int i = 0; i < 16; i++) begin
      pop_rx(0, d);
      check_output("ovr_pop", d, 8'(i));
    end
    check_output("ovr_drained", rx_empty0, 1);
    pulse_clr(0);
    check_output("ovr_clr", ovr0, 0);

    // 7E1 core: transmitted parity, good and flipped received parity
    fork
      write_tx(1, 8'h07);
      capture_frame(1, 10, "p_tx_start", f, starts[0]);
    join
    check_output("p_tx_frame", f, line_frame(8'h07, 7, 2));
    check_output("p_tx_parbit", f[8], 1);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 127));
      send_bits(1, line_frame(d, 7, 2), 10);
      wait_rx(1, "p_rx_wait");
      check_output("p_rx_noerr", perr1, 0);
      pop_rx(1, f[7:0]);
      check_output("p_rx_data", f[7:0], d);
    end
    f = line_frame(8'h07, 7, 2);
    f[8] = ~f[8];
    send_bits(1, f, 10);
    wait_rx(1, "p_bad_wait");
    check_output("p_bad_data", rx_data1, 7'h07);
    check_output("p_bad_err", perr1, 1);
    pop_rx(1, d);
    pulse_clr(1);
    check_output("p_clr", perr1, 0);

    // Fill the TX FIFO, then reset in data bit 3 of the first frame
    for (int i = 0; i < 17; i++) begin
      tx_data0 = 8'(i * 13);
      tx_wr0 = 1'b1;
      tick(1);
    end
    tx_wr0 = 1'b0;
    check_output("tx_full_set", tx_full0, 1);
    // First frame started 2 cycles after the first write; 16 cycles have gone.
    tick(4 * BIT_CYC + BIT_CYC / 2 - 14);
    check_output("pre_rst_bit3", txd0, 0);
    rst = 1'b0;
    #1;
    check_output("mid_rst_txd", txd0, 1);
    check_output("mid_rst_full", tx_full0, 0);
    tick(2);
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 15 * BIT_CYC; i++) begin
      if (txd0 == 1'b0) lows++;
      tick(1);
    end
    check_output("post_rst_quiet", lows, 0);
  endtask

  initial begin
    rst = 1'b0;
    tx_data0 = '0; tx_wr0 = 1'b0; rx_rd0 = 1'b0; clr0 = 1'b0; drv0 = 1'b1; loop0 = 1'b0;
    tx_data1 = '0; tx_wr1 = 1'b0; rx_rd1 = 1'b0; clr1 = 1'b0; drv1 = 1'b1;
    apply_stimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
